// File: rtl/pll_rst_seq_if.sv
// Control/status bundle between the PLL reset sequencer and the PLL/core side.
interface pll_rst_seq_if;
  logic       pll_locked;
  logic       sw_reset;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [7:0] relock_cnt;
  logic [1:0] state;

  modport master (
    input  pll_locked, sw_reset,
    output pll_rst, sys_reset, ready, relock_cnt, state
  );

  modport slave (
    output pll_locked, sw_reset,
    input  pll_rst, sys_reset, ready, relock_cnt, state
  );
endinterface

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the core reset; any lock loss or software request restarts it.
module pll_rst_seq #(
  parameter int unsigned LOCK_SYNC      = 2,
  parameter int unsigned PLL_RST_CYCLES = 50,
  parameter int unsigned RELOCK_TIMEOUT = 5000000,
  parameter int unsigned STABLE_CYCLES  = 50000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic              refclk,
  input  logic              rst,
  pll_rst_seq_if.master     bus
);

  localparam int unsigned RELOCK_W = 8;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [LOCK_SYNC-1:0] r_sync;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [RELOCK_W-1:0]  r_relock_cnt;
  logic                 r_pll_rst;
  logic                 r_sys_reset;
  logic                 r_ready;

  state_t               w_next;
  logic                 w_lk;
  logic                 w_relock_inc;
  logic                 w_cnt_clr;

  assign w_lk = r_sync[LOCK_SYNC-1];

  // Lock synchronizer; pll_locked is asynchronous to refclk
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[LOCK_SYNC-2:0], bus.pll_locked};
  end

  // Next state: sw_reset beats lock loss, lock loss beats counter expiry
  always_comb begin
    w_next       = r_state;
    w_relock_inc = 1'b0;
    if (bus.sw_reset) begin
      w_next = ST_PLL_RST;
    end else begin
      unique case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) w_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lk)                                     w_next = ST_STABLE;
          else if (r_cnt == CNT_W'(RELOCK_TIMEOUT - 1)) w_next = ST_PLL_RST;
        end
        ST_STABLE: begin
          if (!w_lk)                                   w_next = ST_WAIT_LOCK;
          else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) w_next = ST_RUN;
        end
        ST_RUN: begin
          if (!w_lk) begin
            w_next       = ST_PLL_RST;
            w_relock_inc = 1'b1;
          end
        end
        default: w_next = ST_PLL_RST;
      endcase
    end
    w_cnt_clr = bus.sw_reset || (w_next != r_state);
  end

  // State, counter and outputs all update on the same edge
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_PLL_RST;
      r_cnt        <= '0;
      r_relock_cnt <= '0;
      r_pll_rst    <= 1'b1;
      r_sys_reset  <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      r_pll_rst   <= (w_next == ST_PLL_RST);
      r_sys_reset <= (w_next != ST_RUN);
      r_ready     <= (w_next == ST_RUN);
      if (w_relock_inc && (r_relock_cnt != {RELOCK_W{1'b1}}))
        r_relock_cnt <= r_relock_cnt + RELOCK_W'(1);
    end
  end

  assign bus.pll_rst    = r_pll_rst;
  assign bus.sys_reset  = r_sys_reset;
  assign bus.ready      = r_ready;
  assign bus.relock_cnt = r_relock_cnt;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq: power-up, STABLE glitch, lock loss,
// no-lock retry period, sw_reset priority, relock saturation, async reset.
module tb_pll_rst_seq;

  logic refclk = 1'b0;
  logic rst    = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  pll_rst_seq_if bus ();

  pll_rst_seq #(
    .LOCK_SYNC      (2),
    .PLL_RST_CYCLES (4),
    .RELOCK_TIMEOUT (20),
    .STABLE_CYCLES  (10),
    .CNT_W          (24)
  ) u_dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] st, input int max, input string tag);
    int n = 0;
    while (bus.state != st && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.state), 32'(st));
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, " pll_rst"},    32'(bus.pll_rst),    1);
    check({pfx, " sys_reset"},  32'(bus.sys_reset),  1);
    check({pfx, " ready"},      32'(bus.ready),      0);
    check({pfx, " relock_cnt"}, 32'(bus.relock_cnt), 0);
    check({pfx, " state"},      32'(bus.state),      0);
  endtask

  // Releases rst between edges, then checks the edge-exact power-up sequence
  task automatic power_up(input string pfx);
    repeat (2) @(posedge refclk);
    #2 rst = 1'b0;
    repeat (3) tick();
    check({pfx, " e3 pll_rst"}, 32'(bus.pll_rst), 1);
    check({pfx, " e3 state"},   32'(bus.state),   0);
    tick();
    check({pfx, " e4 pll_rst"}, 32'(bus.pll_rst), 0);
    check({pfx, " e4 state"},   32'(bus.state),   1);
    tick();
    check({pfx, " e5 state"},   32'(bus.state),   2);
    repeat (9) tick();
    check({pfx, " e14 sys_reset"}, 32'(bus.sys_reset), 1);
    check({pfx, " e14 ready"},     32'(bus.ready),     0);
    tick();
    check({pfx, " e15 sys_reset"}, 32'(bus.sys_reset), 0);
    check({pfx, " e15 ready"},     32'(bus.ready),     1);
    check({pfx, " e15 state"},     32'(bus.state),     3);
  endtask

  initial begin
    logic exp_rst;
    bus.pll_locked = 1'b1;
    bus.sw_reset   = 1'b0;

    // 1. power-up with lock tied high
    #1 rst = 1'b1;
    #1 check_reset_vals("t1 reset");
    power_up("t1");

    // 2. sw_reset into PLL_RST, then a 3-cycle lock glitch in STABLE
    bus.sw_reset = 1'b1;
    tick();
    check("t2 sw state",     32'(bus.state),     0);
    check("t2 sw sys_reset", 32'(bus.sys_reset), 1);
    check("t2 sw pll_rst",   32'(bus.pll_rst),   1);
    bus.sw_reset = 1'b0;
    repeat (5) tick();
    check("t2 in stable", 32'(bus.state), 2);
    repeat (2) tick();
    bus.pll_locked = 1'b0;
    repeat (3) tick();
    check("t2 glitch state",   32'(bus.state),   1);
    check("t2 glitch pll_rst", 32'(bus.pll_rst), 0);
    bus.pll_locked = 1'b1;
    repeat (2) tick();
    check("t2 still wait",  32'(bus.state),   1);
    check("t2 no pll_rst",  32'(bus.pll_rst), 0);
    tick();
    check("t2 stable again", 32'(bus.state), 2);
    repeat (9) tick();
    check("t2 stable 9", 32'(bus.state), 2);
    tick();
    check("t2 run",   32'(bus.state), 3);
    check("t2 ready", 32'(bus.ready), 1);

    // 3+4. lock loss in RUN, then lock never returns: 4-high / 24-period pulses
    bus.pll_locked = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      exp_rst = (k >= 3) && (((k - 3) % 24) < 4);
      check($sformatf("t3 k%0d pll_rst", k),   32'(bus.pll_rst),    32'(exp_rst));
      check($sformatf("t3 k%0d sys_reset", k), 32'(bus.sys_reset),  (k >= 3) ? 1 : 0);
      check($sformatf("t3 k%0d ready", k),     32'(bus.ready),      (k >= 3) ? 0 : 1);
      check($sformatf("t3 k%0d relock", k),    32'(bus.relock_cnt), (k >= 3) ? 1 : 0);
      if (k == 3) check("t3 k3 state", 32'(bus.state), 0);
    end

    // 5. sw_reset and lock drop together in RUN: no relock increment
    bus.pll_locked = 1'b1;
    wait_state(2'd3, 100, "t5 reach run");
    bus.sw_reset   = 1'b1;
    bus.pll_locked = 1'b0;
    tick();
    check("t5 state",     32'(bus.state),      0);
    check("t5 relock",    32'(bus.relock_cnt), 1);
    check("t5 sys_reset", 32'(bus.sys_reset),  1);
    bus.sw_reset = 1'b0;
    repeat (5) tick();
    check("t5 relock later", 32'(bus.relock_cnt), 1);

    // 5b. 300 lock losses from RUN saturate the relock counter
    for (int i = 0; i < 300; i++) begin
      bus.pll_locked = 1'b1;
      wait_state(2'd3, 100, "t5 sat run");
      bus.pll_locked = 1'b0;
      wait_state(2'd0, 10, "t5 sat loss");
      if (i == 0)   check("t5 relock first", 32'(bus.relock_cnt), 2);
      if (i == 253) check("t5 relock 255",   32'(bus.relock_cnt), 255);
    end
    check("t5 relock sat", 32'(bus.relock_cnt), 255);

    // 6. async reset mid-STABLE, then the power-up sequence repeats
    bus.pll_locked = 1'b1;
    wait_state(2'd2, 100, "t6 reach stable");
    repeat (3) tick();
    check("t6 mid stable", 32'(bus.state), 2);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6 reset");
    power_up("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

Reset sequencer for the core clock PLL. It runs on the 50 MHz board reference clock, which is the same clock that feeds the PLL. It drives the PLL reset input and consumes the PLL `locked` output. From those it produces a clean, glitch-free system reset and a ready flag for the core. Any loss of lock is detected, the core is forced into reset, and the PLL is re-initialised.

## Interface
Parameters:
- LOCK_SYNC, 2: synchronizer stages on `pll_locked`, must be ≥2.
- PLL_RST_CYCLES, 50: `pll_rst` pulse length in refclk cycles (1 µs).
- RELOCK_TIMEOUT, 5000000: cycles to wait for lock before re-pulsing `pll_rst` (100 ms).
- STABLE_CYCLES, 50000: cycles `locked` must stay high before the core reset is released (1 ms).
- CNT_W, 24: cycle counter width. It must hold max(PLL_RST_CYCLES, RELOCK_TIMEOUT, STABLE_CYCLES)−1.

Ports:
- refclk  in  1  50 MHz reference clock, the only clock.
- rst  in  1  reset, asynchronous assert, active-high.
- pll_locked  in  1  PLL lock indication, asynchronous to refclk.
- sw_reset  in  1  synchronous request to re-initialise the PLL and the core.
- pll_rst  out  1  PLL reset, registered.
- sys_reset  out  1  core reset, active-high, registered.
- ready  out  1  high only in RUN, registered.
- relock_cnt  out  8  saturating count of lock losses while in RUN.
- state  out  2  current state: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN.

## Operation
- `pll_locked` passes through a LOCK_SYNC-flop chain, reset to 0. The FSM uses only the last stage, `lk`.
- The FSM state register and all outputs are flops updated on the same edge. No output is a combinational decode.
- Output values per state:
  - `pll_rst` = 1 in PLL_RST only.
  - `sys_reset` = 0 in RUN only.
  - `ready` = 1 in RUN only.
- Counter `cnt` clears to 0 on every state change. Otherwise it increments each cycle.
- State behaviour:
  - PLL_RST: leave to WAIT_LOCK when `cnt` == PLL_RST_CYCLES−1, so `pll_rst` is high for exactly PLL_RST_CYCLES cycles.
  - WAIT_LOCK: `lk`=1 goes to STABLE. Otherwise `cnt` == RELOCK_TIMEOUT−1 goes to PLL_RST. A timeout does not change `relock_cnt`.
  - STABLE: `lk`=0 goes to WAIT_LOCK and does not pulse `pll_rst`. `cnt` == STABLE_CYCLES−1 with `lk`=1 goes to RUN.
  - RUN: `lk`=0 goes to PLL_RST and increments `relock_cnt`, saturating at 255.
- Priority on each edge, highest first: `sw_reset`, then lock loss, then counter expiry.
  - `sw_reset`=1 in any state goes to PLL_RST with `cnt`=0. In PLL_RST this restarts the pulse.
  - A lock loss in the same cycle as `sw_reset` does not increment `relock_cnt`.
- `relock_cnt` is cleared only by `rst`.

## Timing
- `rst` asserted forces the following immediately, with no clock edge needed:
  - state = PLL_RST, `cnt`=0, synchronizer all 0.
  - `pll_rst`=1, `sys_reset`=1, `ready`=0, `relock_cnt`=0, `state`=0.
- Deassertion of `rst` is taken synchronously. The first active edge is edge 1.
- Lock-loss latency: `sys_reset` rises on edge LOCK_SYNC+1, counted from the first edge that samples `pll_locked` low. This is edge 3 for LOCK_SYNC=2.
- `sw_reset` latency: `sys_reset` and `pll_rst` go high on the edge that samples `sw_reset`=1.
- Lock-acquire latency: `lk` rises LOCK_SYNC edges after `pll_locked` is sampled high. The FSM sees `lk` on the following edge.
- A `pll_locked` glitch shorter than one cycle may be missed. The block makes no requirement either way.

## Test plan
Parameters for all tests unless stated otherwise: LOCK_SYNC=2, PLL_RST_CYCLES=4, RELOCK_TIMEOUT=20, STABLE_CYCLES=10.

1. Power-up: `pll_locked` tied high, `rst` released before edge 1.
   - `pll_rst` goes low on edge 4 and `state` goes 1.
   - `state` goes 2 on edge 5.
   - `sys_reset` goes 0 and `ready` goes 1 on edge 15.
2. Glitch during STABLE: drop `pll_locked` low for 3 cycles.
   - `state` returns to 1 and `pll_rst` stays 0.
   - After lock returns, RUN is reached a full 10 STABLE cycles later.
3. Loss of lock in RUN: drop `pll_locked`.
   - `sys_reset`=1 and `pll_rst`=1 on the 3rd edge.
   - `pll_rst` stays high exactly 4 cycles.
   - `relock_cnt`=1.
4. Never locks: `pll_locked`=0 permanently.
   - `pll_rst` pulses of 4 cycles repeat with a 24-cycle period.
   - `relock_cnt` stays 0 and `ready` stays 0.
5. `sw_reset` and `pll_locked` fall in the same cycle, with the FSM in RUN.
   - `state`=0 on the next edge.
   - `relock_cnt` is unchanged.
   - 300 forced lock losses out of RUN saturate `relock_cnt` at 255.
6. `rst` asserted mid-STABLE, between clock edges.
   - All outputs take their reset values immediately.
   - After release, the sequence from test 1 repeats exactly.
